// File: rtl/id_hazard_ctrl_if.sv
// id_hazard_ctrl_if -- decode-side bundle for the ID hazard controller.
//   master : decode stage (drives instruction/freeze inputs, reads decisions)
//   slave  : id_hazard_ctrl
// Signals:
//   issue_valid, src_reg[NSRC*5], src_used[NSRC], dst_reg[5], dst_we,
//   dst_is_load, serialize, serialize_quiet, ext_stall      (master -> slave)
//   issue_ok, want_freeze, fwd_sel[NSRC*2], sys_pulse, ser_state[2]
//                                                           (slave -> master)
// Optional feature macro: HAZARD_STATS_EN adds stall_cycles[32], ser_events[16].
interface id_hazard_ctrl_if #(
  parameter int NSRC = 2
);
  logic                issue_valid;
  logic [NSRC*5-1:0]   src_reg;
  logic [NSRC-1:0]     src_used;
  logic [4:0]          dst_reg;
  logic                dst_we;
  logic                dst_is_load;
  logic                serialize;
  logic                serialize_quiet;
  logic                ext_stall;
  logic                issue_ok;
  logic                want_freeze;
  logic [NSRC*2-1:0]   fwd_sel;
  logic                sys_pulse;
  logic [1:0]          ser_state;
`ifdef HAZARD_STATS_EN
  logic [31:0]         stall_cycles;
  logic [15:0]         ser_events;
`endif

  modport master (
`ifdef HAZARD_STATS_EN
    input  stall_cycles, ser_events,
`endif
    output issue_valid, src_reg, src_used, dst_reg, dst_we, dst_is_load,
           serialize, serialize_quiet, ext_stall,
    input  issue_ok, want_freeze, fwd_sel, sys_pulse, ser_state
  );

  modport slave (
`ifdef HAZARD_STATS_EN
    output stall_cycles, ser_events,
`endif
    input  issue_valid, src_reg, src_used, dst_reg, dst_we, dst_is_load,
           serialize, serialize_quiet, ext_stall,
    output issue_ok, want_freeze, fwd_sel, sys_pulse, ser_state
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl -- ID-stage hazard controller.
// Load-use scoreboard (32 x 2-bit stall counts), per-source bypass select
// from EXE/MEM tracking slots, and a sequencer that drains the pipe before a
// serialising instruction (syscall / LL / SC) issues.
// Ports:
//   CLK    : clock, all state on posedge
//   RESET  : asynchronous, active-low
//   bus    : id_hazard_ctrl_if.slave (instruction in, issue/freeze/bypass out)
// Optional feature macro: HAZARD_STATS_EN (stall_cycles / ser_events counters).
module id_hazard_ctrl #(
  parameter int NSRC        = 2,
  parameter int LOAD_STALL  = 1,
  parameter int SER_BUBBLES = 4
) (
  input logic             CLK,
  input logic             RESET,
  id_hazard_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_SYS     = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam int             SER_W    = $clog2(SER_BUBBLES) + 1;
  localparam logic [SER_W-1:0] SER_INIT = SER_W'(SER_BUBBLES - 2);
  localparam logic [1:0]     LOAD_CNT = 2'(LOAD_STALL);

  logic [1:0]       count_reg [32];
  logic [4:0]       exe_dst_reg, mem_dst_reg;
  logic             exe_vld_reg, mem_vld_reg;
  logic [1:0]       state_reg, state_next;
  logic [SER_W-1:0] bub_reg, bub_next;
  logic             pulse_reg, pulse_next;
  logic             ser_start;

  logic [NSRC-1:0]   port_hazard;
  logic [NSRC*2-1:0] fwd_all;
  logic              hazard;
  logic              fsm_permit;
  logic              fsm_freeze;
  logic              issue_ok;

  // Per-port hazard detect and bypass select. Duplicate sources are simply
  // evaluated independently on each port.
  for (genvar gi = 0; gi < NSRC; gi++) begin : g_port
    logic [4:0] src;
    logic [1:0] sel;
    assign src = bus.src_reg[5*gi +: 5];
    assign port_hazard[gi] = bus.src_used[gi] && (src != 5'd0) &&
                             (count_reg[src] != 2'd0);
    always_comb begin
      sel = 2'b00;
      if (src != 5'd0) begin
        if (exe_vld_reg && exe_dst_reg == src)      sel = 2'b01;  // youngest wins
        else if (mem_vld_reg && mem_dst_reg == src) sel = 2'b10;
      end
    end
    assign fwd_all[2*gi +: 2] = sel;
  end

  assign hazard = |port_hazard;

  // A serialising op seen in IDLE is held back (and fetch frozen) until the
  // sequencer reaches RELEASE, where freeze is lifted so it can issue.
  assign fsm_permit = (state_reg == ST_RELEASE) ||
                      (state_reg == ST_IDLE && !bus.serialize);
  assign fsm_freeze = (state_reg == ST_DRAIN) || (state_reg == ST_SYS) ||
                      (state_reg == ST_IDLE && bus.issue_valid && bus.serialize);

  assign issue_ok        = bus.issue_valid && !bus.ext_stall && !hazard && fsm_permit;
  assign bus.issue_ok    = issue_ok;
  assign bus.want_freeze = bus.ext_stall | hazard | fsm_freeze;
  assign bus.fwd_sel     = fwd_all;
  assign bus.sys_pulse   = pulse_reg;
  assign bus.ser_state   = state_reg;

  // Scoreboard: a same-cycle (re)set of a register beats its decrement.
  // r0 can never be set because dst_reg != 0 is required, so it stays 0.
  for (genvar gi = 0; gi < 32; gi++) begin : g_sb
    always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
        count_reg[gi] <= 2'd0;
      end else if (!bus.ext_stall) begin
        if (issue_ok && bus.dst_reg != 5'd0 && bus.dst_reg == 5'(gi) && bus.dst_is_load)
          count_reg[gi] <= LOAD_CNT;
        else if (issue_ok && bus.dst_reg != 5'd0 && bus.dst_reg == 5'(gi) && bus.dst_we)
          count_reg[gi] <= 2'd0;
        else if (count_reg[gi] != 2'd0)
          count_reg[gi] <= count_reg[gi] - 2'd1;
      end
    end
  end

  // EXE/MEM tracking slots; a non-issuing cycle inserts an invalid bubble.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      exe_dst_reg <= 5'd0;
      exe_vld_reg <= 1'b0;
      mem_dst_reg <= 5'd0;
      mem_vld_reg <= 1'b0;
    end else if (!bus.ext_stall) begin
      mem_dst_reg <= exe_dst_reg;
      mem_vld_reg <= exe_vld_reg;
      exe_dst_reg <= bus.dst_reg;
      exe_vld_reg <= issue_ok && bus.dst_we && (bus.dst_reg != 5'd0);
    end
  end

  // Sequencer. bub_reg holds the DRAIN cycles still to run; SYS is entered
  // when the last one completes so the pulse register is high during SYS and
  // the op issues in the following (RELEASE) cycle.
  always_comb begin
    state_next = state_reg;
    bub_next   = bub_reg;
    pulse_next = 1'b0;
    ser_start  = 1'b0;
    if (!bus.ext_stall) begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.issue_valid && bus.serialize) begin
            ser_start = 1'b1;
            bub_next  = SER_INIT;
            if (SER_BUBBLES <= 2) begin
              state_next = ST_SYS;
              pulse_next = !bus.serialize_quiet;
            end else begin
              state_next = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (bub_reg != '0) bub_next = bub_reg - SER_W'(1);
          if (bub_reg <= SER_W'(1)) begin
            state_next = ST_SYS;
            pulse_next = !bus.serialize_quiet;
          end
        end
        ST_SYS:  state_next = ST_RELEASE;
        default: if (issue_ok) state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= ST_IDLE;
      bub_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      bub_reg   <= bub_next;
      pulse_reg <= pulse_next;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_reg;
  logic [15:0] ser_events_reg;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_cycles_reg <= 32'd0;
      ser_events_reg   <= 16'd0;
    end else begin
      if (bus.issue_valid && !issue_ok && !bus.ext_stall && stall_cycles_reg != 32'hFFFF_FFFF)
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (ser_start)
        ser_events_reg <= ser_events_reg + 16'd1;  // wraps
    end
  end

  assign bus.stall_cycles = stall_cycles_reg;
  assign bus.ser_events   = ser_events_reg;
`endif
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl -- directed scenarios followed by random traffic, all
// checked each cycle against a behavioural model of the hazard rules.
module tb_id_hazard_ctrl;
  localparam int NSRC = 2;
  localparam int LS   = 1;
  localparam int SB   = 4;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  id_hazard_ctrl_if #(.NSRC(NSRC)) bus ();

  id_hazard_ctrl #(.NSRC(NSRC), .LOAD_STALL(LS), .SER_BUBBLES(SB)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: pending load-use stall per register, destinations issued
  // over the last two unstalled cycles (newest first, -1 = nothing), and the
  // age of an in-progress serialising op in unstalled cycles.
  int mcount [32];
  int hist [$];
  bit ser_active;
  int age;
  bit pulse_exp;
  int m_stalls;
  int m_sers;

  logic [3:0] last_fwd;
  logic       last_ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) mcount[r] = 0;
    hist.delete();
    ser_active = 1'b0;
    age = 0;
    pulse_exp = 1'b0;
    m_stalls = 0;
    m_sers = 0;
  endtask

  task automatic drive_idle();
    bus.issue_valid = 0; bus.src_reg = '0; bus.src_used = '0; bus.dst_reg = '0;
    bus.dst_we = 0; bus.dst_is_load = 0; bus.serialize = 0;
    bus.serialize_quiet = 0; bus.ext_stall = 0;
  endtask

  task automatic step(input logic iv, input logic [4:0] s0, input logic [4:0] s1,
                      input logic [1:0] used, input logic [4:0] dst, input logic we,
                      input logic ld, input logic ser, input logic quiet,
                      input logic stall);
    logic [4:0] src [2];
    bit hz, permit, ffsm, ok_m, frz_m;
    logic [3:0] fwd_m;
    @(negedge CLK);
    bus.issue_valid = iv; bus.src_reg = {s1, s0}; bus.src_used = used;
    bus.dst_reg = dst; bus.dst_we = we; bus.dst_is_load = ld;
    bus.serialize = ser; bus.serialize_quiet = quiet; bus.ext_stall = stall;
    #1;
    src[0] = s0; src[1] = s1;
    hz = 0;
    fwd_m = '0;
    for (int p = 0; p < 2; p++) begin
      if (used[p] && src[p] != 0 && mcount[src[p]] != 0) hz = 1;
      if (src[p] != 0) begin
        if (hist.size() > 0 && hist[0] == int'(src[p]))      fwd_m[2*p +: 2] = 2'b01;
        else if (hist.size() > 1 && hist[1] == int'(src[p])) fwd_m[2*p +: 2] = 2'b10;
      end
    end
    permit = ser_active ? (age >= SB) : !ser;
    ffsm   = ser_active ? (age < SB) : (iv && ser);
    ok_m   = iv && !stall && !hz && permit;
    frz_m  = stall || hz || ffsm;
    chk("issue_ok", bus.issue_ok, ok_m);
    chk("want_freeze", bus.want_freeze, frz_m);
    chk("fwd_sel", bus.fwd_sel, fwd_m);
    chk("sys_pulse", bus.sys_pulse, pulse_exp);
    chk("ser_idle", bus.ser_state == 2'd0, !ser_active);
`ifdef HAZARD_STATS_EN
    chk("stall_cycles", bus.stall_cycles, m_stalls);
    chk("ser_events", bus.ser_events, m_sers);
`endif
    last_fwd = bus.fwd_sel;
    last_ok  = bus.issue_ok;
    @(posedge CLK);
    pulse_exp = 1'b0;
    if (!stall) begin
      if (iv && !ok_m) m_stalls++;
      for (int r = 0; r < 32; r++) if (mcount[r] > 0) mcount[r]--;
      if (ok_m && dst != 0) begin
        if (ld) mcount[dst] = LS;
        else if (we) mcount[dst] = 0;
      end
      hist.push_front((ok_m && we && dst != 0) ? int'(dst) : -1);
      if (hist.size() > 2) void'(hist.pop_back());
      if (!ser_active) begin
        if (iv && ser) begin
          ser_active = 1'b1;
          age = 1;
          m_sers++;
          if (age == SB - 1) pulse_exp = !quiet;
        end
      end else if (age >= SB) begin
        if (ok_m) ser_active = 1'b0;
      end else begin
        age++;
        if (age == SB - 1) pulse_exp = !quiet;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    drive_idle();
    #1;
    chk("rst_ser_idle", bus.ser_state == 2'd0, 1'b1);
    chk("rst_sys_pulse", bus.sys_pulse, 1'b0);
    chk("rst_fwd_sel", bus.fwd_sel, 4'b0000);
    model_reset();
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    logic [4:0] rs0, rs1, rd;
    logic       r_ld, r_we, r_ser, r_q, r_st, r_iv;
    logic [1:0] r_used;

    drive_idle();
    model_reset();
    repeat (2) @(posedge CLK);
    do_reset();

    // Load r5 then a dependent reader on port 1: one stall, then MEM bypass.
    step(1, 0, 0, 2'b00, 5, 1, 1, 0, 0, 0);
    step(1, 0, 5, 2'b10, 9, 1, 0, 0, 0, 0);
    chk("sc1_stalled", last_ok, 1'b0);
    step(1, 0, 5, 2'b10, 9, 1, 0, 0, 0, 0);
    chk("sc1_issue", last_ok, 1'b1);
    chk("sc1_fwd_mem", last_fwd[3:2], 2'b10);

    // ALU writes r7, read on both ports twice: EXE then MEM bypass.
    step(1, 0, 0, 2'b00, 7, 1, 0, 0, 0, 0);
    step(1, 7, 7, 2'b11, 0, 0, 0, 0, 0, 0);
    chk("sc2_fwd_exe", last_fwd, 4'b0101);
    step(1, 7, 7, 2'b11, 0, 0, 0, 0, 0, 0);
    chk("sc2_fwd_mem", last_fwd, 4'b1010);

    // Syscall: bubbles, pulse, issue. Then LL (quiet) with the same timing.
    repeat (5) step(1, 2, 0, 2'b01, 2, 1, 0, 1, 0, 0);
    chk("sc3_issue", last_ok, 1'b1);
    step(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (5) step(1, 4, 0, 2'b01, 6, 1, 1, 1, 1, 0);
    step(1, 6, 0, 2'b01, 0, 0, 0, 0, 0, 0);

    // ext_stall for 3 cycles during DRAIN delays the pulse by 3.
    step(1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1);
    repeat (4) step(1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);

    // Load r3 then r3 reader held under ext_stall: count frozen.
    step(1, 0, 0, 2'b00, 3, 1, 1, 0, 0, 0);
    repeat (3) step(1, 3, 0, 2'b01, 8, 1, 0, 0, 0, 1);
    step(1, 3, 0, 2'b01, 8, 1, 0, 0, 0, 0);
    chk("sc5_still_stalled", last_ok, 1'b0);
    step(1, 3, 0, 2'b01, 8, 1, 0, 0, 0, 0);

    // Load to r0 never stalls or forwards.
    step(1, 0, 0, 2'b00, 0, 1, 1, 0, 0, 0);
    step(1, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0);
    chk("sc6_r0_fwd", last_fwd, 4'b0000);

    // Reset during DRAIN with a load pending: everything cleared, no pulse.
    step(1, 0, 0, 2'b00, 9, 1, 1, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 0);
    do_reset();
    repeat (4) step(1, 9, 9, 2'b11, 0, 0, 0, 0, 0, 0);

    // Random traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      r_iv   = ($urandom_range(0, 9) < 8);
      rs0    = 5'($urandom_range(0, 7));
      rs1    = 5'($urandom_range(0, 7));
      r_used = 2'($urandom_range(0, 3));
      rd     = 5'($urandom_range(0, 7));
      r_ld   = ($urandom_range(0, 9) < 3);
      r_we   = r_ld | ($urandom_range(0, 9) < 6);
      r_ser  = ($urandom_range(0, 19) == 0);
      r_q    = 1'($urandom_range(0, 1));
      r_st   = ($urandom_range(0, 19) < 3);
      step(r_iv, rs0, rs1, r_used, rd, r_we, r_ld, r_ser, r_q, r_st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
